// File: rtl/vfpu_package.sv
// Shared types and constants for the SIMD integer arithmetic stage.
package vfpu_package;

    localparam int unsigned LANE_WIDTH = 32;

    typedef enum logic [1:0] {
        VFPU_ADD = 2'd0,
        VFPU_SUB = 2'd1,
        VFPU_MUL = 2'd2,
        VFPU_MAX = 2'd3
    } vfpu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vfpu_engine_state_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready data stream with byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
    modport master (output valid, output data, output strb, input ready);
    modport slave  (input valid, input data, input strb, output ready);

endinterface

// File: rtl/vfpu_lane.sv
// Combinational 32-bit ALU for a single SIMD lane.
module vfpu_lane
    import vfpu_package::*;
(
    input  vfpu_op_t              op_i,
    input  logic [LANE_WIDTH-1:0] a_i,
    input  logic [LANE_WIDTH-1:0] b_i,
    output logic [LANE_WIDTH-1:0] res_o
);

    // Lane operation, all modulo 2^32; MAX compares as signed
    always_comb begin
        res_o = '0;
        case (op_i)
            VFPU_ADD: res_o = a_i + b_i;
            VFPU_SUB: res_o = a_i - b_i;
            VFPU_MUL: res_o = a_i * b_i;
            VFPU_MAX: res_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
            default:  res_o = '0;
        endcase
    end

endmodule

// File: rtl/vfpu_engine.sv
// Two-stage SIMD integer pipeline with job control and backpressure.
module vfpu_engine
    import vfpu_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    hwpe_stream_intf_stream.sink   a_i,
    hwpe_stream_intf_stream.sink   b_i,
    hwpe_stream_intf_stream.source r_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  cnt_o
);

    localparam int unsigned LANES      = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]           state_q, state_d;
    vfpu_op_t             op_q, op_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;

    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_a_q;
    logic [DATA_WIDTH-1:0] s1_b_q;
    logic [STRB_WIDTH-1:0] s1_strb_q;
    vfpu_op_t              s1_op_q;

    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_data_q;
    logic [STRB_WIDTH-1:0] s2_strb_q;

    logic [DATA_WIDTH-1:0] lane_res;
    logic                  soft_rst_c;
    logic                  enable_c;
    logic                  accept_c;
    logic                  emit_c;

    assign soft_rst_c = rst_i | clear_i;
    assign enable_c   = ~s2_valid_q | r_o.ready;
    // Both operands are taken together, only while the job still needs pairs
    assign accept_c   = ~soft_rst_c & (state_q == ST_RUN) & (acc_q < len_q)
                        & a_i.valid & b_i.valid & enable_c;
    assign emit_c     = s2_valid_q & r_o.ready;

    assign a_i.ready = accept_c;
    assign b_i.ready = accept_c;
    assign r_o.valid = s2_valid_q;
    assign r_o.data  = s2_data_q;
    assign r_o.strb  = s2_strb_q;

    assign busy_o = (state_q == ST_RUN);
    assign done_o = done_q;
    assign cnt_o  = cnt_q;

    // Job control state register
    always_ff @(posedge clk_i) begin
        if (soft_rst_c) begin
            state_q <= ST_IDLE;
            op_q    <= VFPU_ADD;
            len_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state: job start, accept/emit counting, completion
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d  = vfpu_op_t'(op_i);
                    len_d = len_i;
                    acc_d = '0;
                    cnt_d = '0;
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    acc_d = acc_q + CNT_WIDTH'(1);
                end
                if (emit_c) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q + CNT_WIDTH'(1) == len_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane ALUs operate on the S1 operands
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vfpu_lane u_lane (
            .op_i  (s1_op_q),
            .a_i   (s1_a_q[l*LANE_WIDTH +: LANE_WIDTH]),
            .b_i   (s1_b_q[l*LANE_WIDTH +: LANE_WIDTH]),
            .res_o (lane_res[l*LANE_WIDTH +: LANE_WIDTH])
        );
    end

    // S1/S2 pipeline registers; both hold when the sink stalls a full S2
    always_ff @(posedge clk_i) begin
        if (soft_rst_c) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_strb_q  <= '0;
            s1_op_q    <= VFPU_ADD;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_strb_q  <= '0;
        end else if (enable_c) begin
            s1_valid_q <= accept_c;
            if (accept_c) begin
                s1_a_q    <= a_i.data;
                s1_b_q    <= b_i.data;
                s1_strb_q <= a_i.strb & b_i.strb;
                s1_op_q   <= op_q;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= lane_res;
                s2_strb_q <= s1_strb_q;
            end
        end
    end

endmodule
